// File: rtl/cv32e40p_div_issue.sv
// Issue/response front-end for the serial divider: registers a request, normalises
// operand B, starts the divider and buffers its result until writeback takes it.
module cv32e40p_div_issue #(
  parameter int unsigned C_WIDTH     = 32,
  parameter int unsigned C_LOG_WIDTH = 6
) (
  input  logic                   Clk_CI,
  input  logic                   Rst_RBI,
  input  logic                   ReqVld_SI,
  output logic                   ReqRdy_SO,
  input  logic [C_WIDTH-1:0]     ReqOpA_DI,
  input  logic [C_WIDTH-1:0]     ReqOpB_DI,
  input  logic [1:0]             ReqOpCode_SI,
  input  logic                   Flush_SI,
  output logic                   RspVld_SO,
  input  logic                   RspRdy_SI,
  output logic [C_WIDTH-1:0]     RspRes_DO,
  output logic [C_WIDTH-1:0]     DivOpA_DO,
  output logic [C_WIDTH-1:0]     DivOpB_DO,
  output logic [C_LOG_WIDTH-1:0] DivOpBShift_DO,
  output logic                   DivOpBIsZero_SO,
  output logic                   DivOpBSign_SO,
  output logic [1:0]             DivOpCode_SO,
  output logic                   DivInVld_SO,
  input  logic                   DivOutVld_SI,
  output logic                   DivOutRdy_SO,
  input  logic [C_WIDTH-1:0]     DivRes_DI
);

  localparam logic [C_LOG_WIDTH-1:0] MaxShift = C_LOG_WIDTH'(C_WIDTH - 1);

  typedef enum logic [2:0] {StIdle, StPrep, StIssue, StWait, StResp} state_e;

  state_e                 state_q, state_d;
  logic                   drop_q, drop_d;
  logic                   req_fire, res_we;
  logic [C_WIDTH-1:0]     op_a_q, op_b_q;
  logic [1:0]             opcode_q;
  logic                   lead_bit, lead_done;
  logic [C_LOG_WIDTH-1:0] lead_cnt, shift_raw, shift;
  logic [C_WIDTH-1:0]     div_op_a_q, div_op_b_q, res_q;
  logic [C_LOG_WIDTH-1:0] div_shift_q;
  logic                   div_zero_q, div_sign_q;
  logic [1:0]             div_opcode_q;

  // Signed operands count copies of the sign bit; unsigned ones count leading zeros.
  always_comb begin
    lead_bit  = opcode_q[0] & op_b_q[C_WIDTH-1];
    lead_cnt  = '0;
    lead_done = 1'b0;
    for (int i = C_WIDTH - 1; i >= 0; i--) begin
      if (!lead_done && (op_b_q[i] == lead_bit)) begin
        lead_cnt = lead_cnt + C_LOG_WIDTH'(1);
      end else begin
        lead_done = 1'b1;
      end
    end
    if (op_b_q == '0) begin
      shift_raw = MaxShift;
    end else if (opcode_q[0]) begin
      shift_raw = lead_cnt - C_LOG_WIDTH'(1);
    end else begin
      shift_raw = lead_cnt;
    end
    shift = (shift_raw > MaxShift) ? MaxShift : shift_raw;
  end

  always_comb begin
    state_d      = state_q;
    drop_d       = drop_q;
    req_fire     = 1'b0;
    res_we       = 1'b0;
    ReqRdy_SO    = 1'b0;
    DivInVld_SO  = 1'b0;
    DivOutRdy_SO = 1'b0;
    RspVld_SO    = 1'b0;
    unique case (state_q)
      StIdle: begin
        ReqRdy_SO = ~Flush_SI;
        if (ReqVld_SI && !Flush_SI) begin
          req_fire = 1'b1;
          drop_d   = 1'b0;
          state_d  = StPrep;
        end
      end
      StPrep: state_d = Flush_SI ? StIdle : StIssue;
      StIssue: begin
        DivInVld_SO = 1'b1;
        state_d     = StWait;
        if (Flush_SI) drop_d = 1'b1;
      end
      StWait: begin
        if (Flush_SI) drop_d = 1'b1;
        // A killed request still drains the divider so its handshake stays intact.
        if (DivOutVld_SI) begin
          DivOutRdy_SO = 1'b1;
          res_we       = ~(drop_q | Flush_SI);
          drop_d       = 1'b0;
          state_d      = res_we ? StResp : StIdle;
        end
      end
      StResp: begin
        RspVld_SO = 1'b1;
        if (RspRdy_SI || Flush_SI) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI) begin
      state_q <= StIdle;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
    end
  end

  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI) begin
      op_a_q       <= '0;
      op_b_q       <= '0;
      opcode_q     <= '0;
      div_op_a_q   <= '0;
      div_op_b_q   <= '0;
      div_shift_q  <= '0;
      div_zero_q   <= 1'b0;
      div_sign_q   <= 1'b0;
      div_opcode_q <= '0;
      res_q        <= '0;
    end else begin
      if (req_fire) begin
        op_a_q   <= ReqOpA_DI;
        op_b_q   <= ReqOpB_DI;
        opcode_q <= ReqOpCode_SI;
      end
      // Divider inputs only change here, so they hold through the whole division.
      if (state_q == StPrep) begin
        div_op_a_q   <= op_a_q;
        div_op_b_q   <= op_b_q << shift;
        div_shift_q  <= shift;
        div_zero_q   <= (op_b_q == '0);
        div_sign_q   <= lead_bit;
        div_opcode_q <= opcode_q;
      end
      if (res_we) res_q <= DivRes_DI;
    end
  end

  assign RspRes_DO       = res_q;
  assign DivOpA_DO       = div_op_a_q;
  assign DivOpB_DO       = div_op_b_q;
  assign DivOpBShift_DO  = div_shift_q;
  assign DivOpBIsZero_SO = div_zero_q;
  assign DivOpBSign_SO   = div_sign_q;
  assign DivOpCode_SO    = div_opcode_q;

endmodule
